// File: rtl/multicycle_ctrl_if.sv
// Control/status bundle between the multi-cycle RV32I controller (master) and its datapath (slave):
// IR fields, ALU flag and memory handshake in, per-cycle strobes, mux selects and fault status out.
interface multicycle_ctrl_if;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7_5;
  logic       zero;
  logic       mem_ready;

  logic       mem_req;
  logic       mem_we;
  logic       adr_src;
  logic       ir_we;
  logic       pc_we;
  logic       reg_we;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] result_src;
  logic [2:0] alu_ctrl;
  logic       instr_done;
  logic       fault;
  logic [1:0] fault_cause;

  modport master (
    input  opcode, funct3, funct7_5, zero, mem_ready,
    output mem_req, mem_we, adr_src, ir_we, pc_we, reg_we,
           alu_src_a, alu_src_b, result_src, alu_ctrl,
           instr_done, fault, fault_cause
  );

  modport slave (
    output opcode, funct3, funct7_5, zero, mem_ready,
    input  mem_req, mem_we, adr_src, ir_we, pc_we, reg_we,
           alu_src_a, alu_src_b, result_src, alu_ctrl,
           instr_done, fault, fault_cause
  );
endinterface

// File: rtl/multicycle_ctrl.sv
// Main FSM of the multi-cycle RV32I core: sequences PC/IR, ALU, register file and the single memory port.
// Optional feature macro ILLEGAL_TRAP_EN: illegal instructions trap to FAULT instead of retiring as a NOP.
module multicycle_ctrl #(
  parameter int MEM_TIMEOUT = 16
) (
  input logic              clk,
  input logic              rst,
  multicycle_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_EXEC_R, S_EXEC_I, S_ALU_WB, S_BRANCH, S_JAL, S_LUI, S_FAULT
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_TIMEOUT = 2'b10
  } cause_e;

  typedef struct packed {
    logic       mem_req;
    logic       mem_we;
    logic       adr_src;
    logic       ir_we;
    logic       pc_we;
    logic       reg_we;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] result_src;
    logic [2:0] alu_ctrl;
    logic       instr_done;
  } ctrl_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;
  localparam logic [1:0] SRCA_ZERO  = 2'b11;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_IMM   = 2'b01;
  localparam logic [1:0] SRCB_FOUR  = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam bit TIMEOUT_EN = (MEM_TIMEOUT > 0);
  localparam int CNT_W      = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam int CNT_MAX_I  = (MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_MAX_I[CNT_W-1:0];

  state_e           state_q, state_d;
  cause_e           cause_q, cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  state_e     dec_next;
  logic       dec_illegal;
  logic [2:0] alu_op;
  logic       mem_wait;
  logic       timeout_hit;
  ctrl_t      ctrl;
  ctrl_t      ctrl_out;

  // Instruction classification, evaluated while the IR is stable in DECODE.
  always_comb begin
    dec_next    = S_FETCH;
    dec_illegal = 1'b0;
    unique case (bus.opcode)
      OP_LOAD, OP_STORE: dec_next = S_MEM_ADDR;
      OP_R, OP_I: begin
        if (bus.funct3 inside {3'b000, 3'b010, 3'b110, 3'b111})
          dec_next = (bus.opcode == OP_R) ? S_EXEC_R : S_EXEC_I;
        else
          dec_illegal = 1'b1;
      end
      OP_BRANCH: begin
        if (bus.funct3 inside {3'b000, 3'b001}) dec_next = S_BRANCH;
        else                                    dec_illegal = 1'b1;
      end
      OP_JAL:  dec_next = S_JAL;
      OP_LUI:  dec_next = S_LUI;
      default: dec_illegal = 1'b1;
    endcase
  end

  // SUB only exists for R-type; ADDI ignores IR[30].
  always_comb begin
    alu_op = ALU_ADD;
    case (bus.funct3)
      3'b000:  alu_op = (state_q == S_EXEC_R && bus.funct7_5) ? ALU_SUB : ALU_ADD;
      3'b010:  alu_op = ALU_SLT;
      3'b110:  alu_op = ALU_OR;
      3'b111:  alu_op = ALU_AND;
      default: alu_op = ALU_ADD;
    endcase
  end

  assign mem_wait    = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout_hit = TIMEOUT_EN && mem_wait && !bus.mem_ready && (cnt_q == CNT_MAX);

  // NOTE: every variable assigned here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    ctrl    = '0;

    unique case (state_q)
      S_FETCH: begin
        ctrl.mem_req    = 1'b1;
        ctrl.alu_src_a  = SRCA_PC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALU;
        if (bus.mem_ready) begin
          ctrl.ir_we = 1'b1;
          ctrl.pc_we = 1'b1;
          state_d    = S_DECODE;
        end
      end
      S_DECODE: begin
        // Branch/jump target is precomputed into ALUOut here.
        ctrl.alu_src_a = SRCA_OLDPC;
        ctrl.alu_src_b = SRCB_IMM;
        if (dec_illegal) begin
`ifdef ILLEGAL_TRAP_EN
          state_d = S_FAULT;
          if (cause_q == CAUSE_NONE) cause_d = CAUSE_ILLEGAL;
`else
          state_d         = S_FETCH;
          ctrl.instr_done = 1'b1;
`endif
        end else begin
          state_d = dec_next;
        end
      end
      S_MEM_ADDR: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = (bus.opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
      end
      S_MEM_RD: begin
        ctrl.mem_req = 1'b1;
        ctrl.adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        ctrl.result_src = RES_MEM;
        ctrl.reg_we     = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_MEM_WR: begin
        ctrl.mem_req = 1'b1;
        ctrl.mem_we  = 1'b1;
        ctrl.adr_src = 1'b1;
        if (bus.mem_ready) begin
          ctrl.instr_done = 1'b1;
          state_d         = S_FETCH;
        end
      end
      S_EXEC_R: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_RS2;
        ctrl.alu_ctrl  = alu_op;
        state_d        = S_ALU_WB;
      end
      S_EXEC_I: begin
        ctrl.alu_src_a = SRCA_RS1;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_ctrl  = alu_op;
        state_d        = S_ALU_WB;
      end
      S_ALU_WB: begin
        ctrl.result_src = RES_ALUOUT;
        ctrl.reg_we     = 1'b1;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_BRANCH: begin
        ctrl.alu_src_a  = SRCA_RS1;
        ctrl.alu_src_b  = SRCB_RS2;
        ctrl.alu_ctrl   = ALU_SUB;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_we      = (bus.funct3 == 3'b000) ? bus.zero : !bus.zero;
        ctrl.instr_done = 1'b1;
        state_d         = S_FETCH;
      end
      S_JAL: begin
        // PC takes the target from ALUOut while the ALU forms the link value oldPC+4.
        ctrl.alu_src_a  = SRCA_OLDPC;
        ctrl.alu_src_b  = SRCB_FOUR;
        ctrl.result_src = RES_ALUOUT;
        ctrl.pc_we      = 1'b1;
        state_d         = S_ALU_WB;
      end
      S_LUI: begin
        ctrl.alu_src_a = SRCA_ZERO;
        ctrl.alu_src_b = SRCB_IMM;
        state_d        = S_ALU_WB;
      end
      S_FAULT: state_d = S_FAULT;
      default: state_d = S_FAULT;
    endcase

    // A ready on the last permitted cycle wins because timeout_hit requires mem_ready low.
    if (timeout_hit) begin
      state_d = S_FAULT;
      if (cause_q == CAUSE_NONE) cause_d = CAUSE_TIMEOUT;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)                            cnt_d = '0;
    else if (TIMEOUT_EN && mem_wait && !bus.mem_ready) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cause_q <= CAUSE_NONE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low combinationally so a reset mid-access drops mem_req immediately.
  assign ctrl_out = rst ? '0 : ctrl;

  assign bus.mem_req     = ctrl_out.mem_req;
  assign bus.mem_we      = ctrl_out.mem_we;
  assign bus.adr_src     = ctrl_out.adr_src;
  assign bus.ir_we       = ctrl_out.ir_we;
  assign bus.pc_we       = ctrl_out.pc_we;
  assign bus.reg_we      = ctrl_out.reg_we;
  assign bus.alu_src_a   = ctrl_out.alu_src_a;
  assign bus.alu_src_b   = ctrl_out.alu_src_b;
  assign bus.result_src  = ctrl_out.result_src;
  assign bus.alu_ctrl    = ctrl_out.alu_ctrl;
  assign bus.instr_done  = ctrl_out.instr_done;
  assign bus.fault       = !rst && (state_q == S_FAULT);
  assign bus.fault_cause = rst ? CAUSE_NONE : cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-instruction expectations from a behavioural model,
// a monitor that summarises DUT activity between instr_done pulses, plus directed fault/reset checks.
module tb_multicycle_ctrl;

  localparam int TO = 4;
  localparam logic [2:0] NONE_OP = 3'b100;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  multicycle_ctrl_if bus ();

  multicycle_ctrl #(.MEM_TIMEOUT(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    int         cycles;
    int         ir_we;
    int         pc_we;
    int         reg_we;
    int         mem_req;
    int         mem_data;
    int         mem_we;
    int         faults;
    logic [1:0] wb_src;
    logic [2:0] rs1_op;
  } summary_t;

  summary_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  bit  mon_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] alu_code(input logic [2:0] f3, input logic sub);
    case (f3)
      3'd0:    return sub ? 3'b001 : 3'b000;
      3'd2:    return 3'b101;
      3'd6:    return 3'b011;
      default: return 3'b010;
    endcase
  endfunction

  // What one instruction should do in total, given its fields and memory stall lengths.
  function automatic summary_t model(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                                     input logic z, input int sf, input int sd);
    summary_t e;
    e.cycles = sf + 1;  e.ir_we = 1;  e.pc_we = 1;  e.reg_we = 0;
    e.mem_req = sf + 1; e.mem_data = 0; e.mem_we = 0; e.faults = 0;
    e.wb_src = 2'b00;   e.rs1_op = NONE_OP;
    case (op)
      7'b0110011, 7'b0010011: begin
        if (f3 inside {3'd0, 3'd2, 3'd6, 3'd7}) begin
          e.cycles += 3; e.reg_we = 1;
          e.rs1_op = alu_code(f3, (op == 7'b0110011) && f75);
        end else e.cycles += 1;
      end
      7'b0000011: begin
        e.cycles += 4 + sd; e.mem_req += sd + 1; e.mem_data = sd + 1;
        e.reg_we = 1; e.wb_src = 2'b01; e.rs1_op = 3'b000;
      end
      7'b0100011: begin
        e.cycles += 3 + sd; e.mem_req += sd + 1; e.mem_data = sd + 1;
        e.mem_we = sd + 1; e.rs1_op = 3'b000;
      end
      7'b1100011: begin
        if (f3 <= 3'd1) begin
          e.cycles += 2; e.rs1_op = 3'b001;
          if ((f3 == 3'd0) ? z : !z) e.pc_we += 1;
        end else e.cycles += 1;
      end
      7'b1101111: begin e.cycles += 3; e.pc_we += 1; e.reg_we = 1; end
      7'b0110111: begin e.cycles += 3; e.reg_we = 1; end
      default:    e.cycles += 1;
    endcase
    return e;
  endfunction

  // Monitor: accumulate activity each cycle, compare against the scoreboard on instr_done.
  initial begin
    summary_t acc;
    summary_t e;
    acc = '{default: 0};
    acc.rs1_op = NONE_OP;
    forever begin
      @(negedge clk);
      #2;
      if (!mon_en) begin
        acc = '{default: 0};
        acc.rs1_op = NONE_OP;
      end else begin
        acc.cycles++;
        acc.ir_we    += int'(bus.ir_we);
        acc.pc_we    += int'(bus.pc_we);
        acc.mem_req  += int'(bus.mem_req);
        acc.mem_data += int'(bus.mem_req && bus.adr_src);
        acc.mem_we   += int'(bus.mem_req && bus.mem_we);
        acc.faults   += int'(bus.fault);
        if (bus.reg_we) begin acc.reg_we++; acc.wb_src = bus.result_src; end
        if (bus.alu_src_a == 2'b10) acc.rs1_op = bus.alu_ctrl;
        if (bus.instr_done) begin
          if (exp_q.size() == 0) begin
            n_checks++; n_fail++;
            $display("FAIL sb_underflow: instr_done with no expected instruction");
          end else begin
            e = exp_q.pop_front();
            check("cycles",   acc.cycles,   e.cycles);
            check("ir_we",    acc.ir_we,    e.ir_we);
            check("pc_we",    acc.pc_we,    e.pc_we);
            check("reg_we",   acc.reg_we,   e.reg_we);
            check("mem_req",  acc.mem_req,  e.mem_req);
            check("mem_data", acc.mem_data, e.mem_data);
            check("mem_we",   acc.mem_we,   e.mem_we);
            check("fault",    acc.faults,   e.faults);
            check("wb_src",   acc.wb_src,   e.wb_src);
            check("rs1_op",   acc.rs1_op,   e.rs1_op);
          end
          acc = '{default: 0};
          acc.rs1_op = NONE_OP;
        end
      end
    end
  end

  // Driver: called at a negedge with the DUT in FETCH; returns at the negedge after instr_done.
  task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                           input logic z, input int sf, input int sd);
    int fc = 0;
    int dc = 0;
    int guard = 0;
    logic done = 1'b0;
    bus.opcode = op; bus.funct3 = f3; bus.funct7_5 = f75; bus.zero = z;
    exp_q.push_back(model(op, f3, f75, z, sf, sd));
    while (!done && guard < 64) begin
      if (bus.mem_req && !bus.adr_src) begin
        bus.mem_ready = (fc >= sf);
        if (fc < sf) fc++;
      end else if (bus.mem_req) begin
        bus.mem_ready = (dc >= sd);
        if (dc < sd) dc++;
      end else begin
        bus.mem_ready = 1'($urandom);
      end
      #1;
      done = bus.instr_done;
      guard++;
      @(negedge clk);
    end
    check("instr_completes", done, 1'b1);
  endtask

  function automatic logic [18:0] all_outputs();
    return {bus.mem_req, bus.mem_we, bus.adr_src, bus.ir_we, bus.pc_we, bus.reg_we,
            bus.alu_src_a, bus.alu_src_b, bus.result_src, bus.alu_ctrl,
            bus.instr_done, bus.fault, bus.fault_cause};
  endfunction

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_outputs_zero", all_outputs(), 19'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_fetch_req", {bus.mem_req, bus.adr_src, bus.alu_src_b}, {1'b1, 1'b0, 2'b10});
    check("post_rst_no_fault",  {bus.fault, bus.fault_cause}, 3'b000);
  endtask

  logic [6:0] ops[7] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                         7'b1100011, 7'b1101111, 7'b0110111};
  logic [2:0] legal_alu_f3[4] = '{3'd0, 3'd2, 3'd6, 3'd7};

  initial begin
    logic [6:0] op;
    logic [2:0] f3;
    bit allow_ill;
`ifdef ILLEGAL_TRAP_EN
    allow_ill = 1'b0;
`else
    allow_ill = 1'b1;
`endif
    rst = 1'b1;
    bus.opcode = '0; bus.funct3 = '0; bus.funct7_5 = 1'b0; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    do_reset();
    mon_en = 1'b1;

    // Directed: ADD, SUB, SLT, stalled LW, branches both ways, JAL, LUI, SW, boundary stalls.
    run_instr(7'b0110011, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(7'b0110011, 3'd0, 1'b1, 1'b0, 0, 0);
    run_instr(7'b0110011, 3'd2, 1'b0, 1'b0, 0, 0);
    run_instr(7'b0000011, 3'd2, 1'b0, 1'b0, 0, 3);
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b1, 0, 0);
    run_instr(7'b1100011, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b1, 0, 0);
    run_instr(7'b1100011, 3'd1, 1'b0, 1'b0, 0, 0);
    run_instr(7'b1101111, 3'd0, 1'b0, 1'b0, 1, 0);
    run_instr(7'b0110111, 3'd0, 1'b0, 1'b0, 0, 0);
    run_instr(7'b0100011, 3'd2, 1'b0, 1'b0, 2, TO - 1);
    run_instr(7'b0010011, 3'd0, 1'b1, 1'b0, TO - 1, 0);

    for (int i = 0; i < 300; i++) begin
      op = ops[$urandom_range(0, 6)];
      f3 = 3'($urandom);
      if (!allow_ill && (op == 7'b0110011 || op == 7'b0010011)) f3 = legal_alu_f3[$urandom_range(0, 3)];
      if (!allow_ill && op == 7'b1100011) f3 = 3'($urandom_range(0, 1));
      if (allow_ill && $urandom_range(0, 9) == 0) op = 7'b1111111;
      run_instr(op, f3, 1'($urandom), 1'($urandom), $urandom_range(0, TO - 1), $urandom_range(0, TO - 1));
    end
    check("sb_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Illegal opcode: DUT is in FETCH at this negedge.
    bus.opcode = 7'b1111111; bus.mem_ready = 1'b1;
    @(negedge clk);
    #1;
`ifdef ILLEGAL_TRAP_EN
    check("ill_no_done", bus.instr_done, 1'b0);
    @(negedge clk);
    #1;
    check("ill_fault", {bus.fault, bus.fault_cause, bus.mem_req}, {1'b1, 2'b01, 1'b0});
    do_reset();
`else
    check("ill_nop_decode", {bus.instr_done, bus.reg_we, bus.pc_we, bus.mem_req}, 4'b1000);
    @(negedge clk);
    #1;
    check("ill_nop_refetch", {bus.mem_req, bus.adr_src, bus.fault}, 3'b100);
`endif

    // Timeout: mem_ready stuck low in FETCH faults after exactly TO cycles.
    bus.opcode = 7'b0110011; bus.mem_ready = 1'b0;
    repeat (TO - 1) @(negedge clk);
    #1;
    check("to_not_yet", {bus.fault, bus.mem_req}, 2'b01);
    @(negedge clk);
    #1;
    check("to_fault", {bus.fault, bus.fault_cause, bus.mem_req}, {1'b1, 2'b10, 1'b0});
    bus.mem_ready = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("to_sticky", {bus.fault, bus.fault_cause, bus.ir_we, bus.pc_we}, {1'b1, 2'b10, 2'b00});
    do_reset();

    // Reset mid-fetch drops mem_req the same cycle.
    bus.mem_ready = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_drop_req", bus.mem_req, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("mid_rst_refetch", {bus.mem_req, bus.fault}, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
